// File: rtl/bp_update_queue_pkg.sv
// Shared widths and sizing for the branch-predictor update queue.
// Predictor-facing widths must track the predictor's own PC and history sizes.
package bp_update_queue_pkg;
    localparam int SIZE_PC            = 32;
    localparam int SIZE_CNT_TBL_LOG   = 8;
    localparam int SIZE_BPQ_DEPTH     = 8;
    localparam int SIZE_BPQ_DEPTH_LOG = 3;
endpackage

// File: rtl/bp_update_queue_if.sv
// Commit-to-predictor update port: retire lanes in, single update request out.
import bp_update_queue_pkg::*;

interface bp_update_queue_if #(
    parameter int PC_W      = SIZE_PC,
    parameter int BHR_W     = SIZE_CNT_TBL_LOG,
    parameter int DEPTH_LOG = SIZE_BPQ_DEPTH_LOG
);
    logic                 cmtValid0_i;
    logic [PC_W-1:0]      cmtPC0_i;
    logic                 cmtDir0_i;
    logic [BHR_W-1:0]     cmtBhr0_i;
    logic                 cmtValid1_i;
    logic [PC_W-1:0]      cmtPC1_i;
    logic                 cmtDir1_i;
    logic [BHR_W-1:0]     cmtBhr1_i;
    logic                 pause_i;
    logic                 ready_o;
    logic                 updateEn_o;
    logic [PC_W-1:0]      updatePC_o;
    logic                 updateDir_o;
    logic [BHR_W-1:0]     updateBhr_o;
    logic [DEPTH_LOG:0]   occupancy_o;
    logic [31:0]          issuedCnt_o;

    modport slave (
        input  cmtValid0_i, cmtPC0_i, cmtDir0_i, cmtBhr0_i,
        input  cmtValid1_i, cmtPC1_i, cmtDir1_i, cmtBhr1_i, pause_i,
        output ready_o, updateEn_o, updatePC_o, updateDir_o, updateBhr_o,
        output occupancy_o, issuedCnt_o
    );

    modport master (
        output cmtValid0_i, cmtPC0_i, cmtDir0_i, cmtBhr0_i,
        output cmtValid1_i, cmtPC1_i, cmtDir1_i, cmtBhr1_i, pause_i,
        input  ready_o, updateEn_o, updatePC_o, updateDir_o, updateBhr_o,
        input  occupancy_o, issuedCnt_o
    );
endinterface

// File: rtl/bp_update_queue_fifo_2w1r.sv
// Circular buffer with two ordered write ports and one read port.
// Writes that do not fit are dropped rather than overwriting the head.
module bp_update_queue_fifo_2w1r #(
    parameter int DEPTH     = 8,
    parameter int DEPTH_LOG = 3,
    parameter int W         = 41
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr0_i,
    input  logic [W-1:0]         wdata0_i,
    input  logic                 wr1_i,
    input  logic [W-1:0]         wdata1_i,
    input  logic                 rd_i,
    output logic [W-1:0]         rdata_o,
    output logic [DEPTH_LOG:0]   count_o
);
    localparam int CW = DEPTH_LOG + 1;

    logic [W-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d, wptr1;
    logic [CW-1:0]        count_q, count_d, free;
    logic                 acc0, acc1, pop;

    always_comb begin
        free    = CW'(DEPTH) - count_q;
        acc0    = wr0_i && (free != '0);
        // lane 1 lands behind lane 0 only when lane 0 actually took a slot
        acc1    = wr1_i && (free > CW'(acc0));
        wptr1   = tail_q + DEPTH_LOG'(acc0);
        pop     = rd_i && (count_q != '0);
        tail_d  = tail_q + DEPTH_LOG'(acc0) + DEPTH_LOG'(acc1);
        head_d  = head_q + DEPTH_LOG'(pop);
        count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) mem_q[tail_q] <= wdata0_i;
        if (acc1) mem_q[wptr1]  <= wdata1_i;
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/bp_update_queue.sv
// Buffers retired conditional branches and feeds them to the predictor one per cycle.
// Non-speculative: only reset discards entries.
import bp_update_queue_pkg::*;

module bp_update_queue #(
    parameter int DEPTH     = SIZE_BPQ_DEPTH,
    parameter int DEPTH_LOG = SIZE_BPQ_DEPTH_LOG,
    parameter int PC_W      = SIZE_PC,
    parameter int BHR_W     = SIZE_CNT_TBL_LOG
) (
    input  logic               clk,
    input  logic               reset,
    bp_update_queue_if.slave   bus
);
    localparam int CW = DEPTH_LOG + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             dir;
        logic [BHR_W-1:0] bhr;
    } entry_t;

    entry_t        wdata0, wdata1, head;
    logic [CW-1:0] count;
    logic          upd_en;
    logic [31:0]   issued_q, issued_d;

    assign wdata0 = '{pc: bus.cmtPC0_i, dir: bus.cmtDir0_i, bhr: bus.cmtBhr0_i};
    assign wdata1 = '{pc: bus.cmtPC1_i, dir: bus.cmtDir1_i, bhr: bus.cmtBhr1_i};

    bp_update_queue_fifo_2w1r #(
        .DEPTH     (DEPTH),
        .DEPTH_LOG (DEPTH_LOG),
        .W         ($bits(entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr0_i    (bus.cmtValid0_i),
        .wdata0_i (wdata0),
        .wr1_i    (bus.cmtValid1_i),
        .wdata1_i (wdata1),
        .rd_i     (upd_en),
        .rdata_o  (head),
        .count_o  (count)
    );

    always_comb begin
        upd_en   = (count != '0) && !bus.pause_i && !reset;
        issued_d = issued_q + 32'(upd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) issued_q <= '0;
        else       issued_q <= issued_d;
    end

    // ready looks only at registered count, so a same-cycle pop never frees room early
    assign bus.ready_o     = !reset && (count <= CW'(DEPTH - 2));
    assign bus.updateEn_o  = upd_en;
    assign bus.updatePC_o  = upd_en ? head.pc  : '0;
    assign bus.updateDir_o = upd_en ? head.dir : 1'b0;
    assign bus.updateBhr_o = upd_en ? head.bhr : '0;
    assign bus.occupancy_o = count;
    assign bus.issuedCnt_o = issued_q;

    a_no_retire_when_full: assert property (@(posedge clk) disable iff (reset)
        (bus.cmtValid0_i || bus.cmtValid1_i) |-> bus.ready_o);
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_bp_update_queue;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic        dir;
        logic [7:0]  bhr;
    } ent_t;

    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;

    bp_update_queue_if bus();

    bp_update_queue dut (.clk(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    ent_t        mq[$];
    logic [31:0] m_issued = 0;
    logic        en_x;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered queue, one pop per unpaused cycle, lanes appended in program order.
    always @(posedge clk) begin
        int   free;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_issued = 0;
        end else begin
            free = DEPTH - mq.size();
            if (mq.size() != 0 && !bus.pause_i) begin
                void'(mq.pop_front());
                m_issued = m_issued + 1;
            end
            if (bus.cmtValid0_i && free > 0) begin
                e = '{bus.cmtPC0_i, bus.cmtDir0_i, bus.cmtBhr0_i};
                mq.push_back(e);
                free--;
            end
            if (bus.cmtValid1_i && free > 0) begin
                e = '{bus.cmtPC1_i, bus.cmtDir1_i, bus.cmtBhr1_i};
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        en_x = (mq.size() != 0) && !bus.pause_i && !rst;
        chk("updateEn",  bus.updateEn_o,  en_x);
        chk("updatePC",  bus.updatePC_o,  en_x ? mq[0].pc  : 32'h0);
        chk("updateDir", bus.updateDir_o, en_x ? mq[0].dir : 1'b0);
        chk("updateBhr", bus.updateBhr_o, en_x ? mq[0].bhr : 8'h0);
        chk("occupancy", bus.occupancy_o, mq.size());
        chk("ready",     bus.ready_o,     !rst && (mq.size() <= DEPTH - 2));
        chk("issuedCnt", bus.issuedCnt_o, m_issued);
    end

    task automatic step(input logic v0, input logic [31:0] pc0, input logic d0, input logic [7:0] b0,
                        input logic v1, input logic [31:0] pc1, input logic d1, input logic [7:0] b1,
                        input logic p, input logic r);
        @(negedge clk);
        #1;
        bus.cmtValid0_i = v0; bus.cmtPC0_i = pc0; bus.cmtDir0_i = d0; bus.cmtBhr0_i = b0;
        bus.cmtValid1_i = v1; bus.cmtPC1_i = pc1; bus.cmtDir1_i = d1; bus.cmtBhr1_i = b1;
        bus.pause_i = p;
        rst = r;
    endtask

    task automatic idle(input logic p);
        step(0, 0, 0, 0, 0, 0, 0, 0, p, 0);
    endtask

    initial begin
        logic [31:0] exp_pc [6];
        bus.cmtValid0_i = 0; bus.cmtPC0_i = 0; bus.cmtDir0_i = 0; bus.cmtBhr0_i = 0;
        bus.cmtValid1_i = 0; bus.cmtPC1_i = 0; bus.cmtDir1_i = 0; bus.cmtBhr1_i = 0;
        bus.pause_i = 0;

        // reset
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("rst_ready", bus.ready_o, 0);
        chk("rst_en", bus.updateEn_o, 0);
        idle(0);
        #2;
        chk("post_rst_occ", bus.occupancy_o, 0);
        chk("post_rst_issued", bus.issuedCnt_o, 0);
        chk("post_rst_ready", bus.ready_o, 1);

        // single branch, one-cycle latency, no bypass
        step(1, 32'h1000, 1, 8'h55, 0, 0, 0, 0, 0, 0);
        #2;
        chk("no_bypass_en", bus.updateEn_o, 0);
        idle(0);
        #2;
        chk("t1_en", bus.updateEn_o, 1);
        chk("t1_pc", bus.updatePC_o, 32'h1000);
        chk("t1_dir", bus.updateDir_o, 1);
        chk("t1_bhr", bus.updateBhr_o, 8'h55);
        idle(0);
        #2;
        chk("t1_en_after", bus.updateEn_o, 0);
        chk("t1_issued", bus.issuedCnt_o, 1);

        // both lanes for 4 cycles while paused -> fills to 8
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h3000 + 8 * i, i[0], 8'(i), 1, 32'h3004 + 8 * i, ~i[0], 8'(8'h80 + i), 1, 0);
            #2;
            if (i == 3) chk("fill6_ready", bus.ready_o, 1);
        end
        idle(0);
        #2;
        chk("full_occ", bus.occupancy_o, 8);
        chk("full_ready", bus.ready_o, 0);
        chk("drain_pc0", bus.updatePC_o, 32'h3000);
        idle(0);
        #2;
        chk("drain_pc1", bus.updatePC_o, 32'h3004);
        for (int i = 0; i < 7; i++) idle(0);
        #2;
        chk("drained_occ", bus.occupancy_o, 0);
        chk("drained_issued", bus.issuedCnt_o, 9);

        // lane 1 alone behind one queued entry
        step(1, 32'h2000, 0, 8'h11, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 32'h2004, 1, 8'h22, 1, 0);
        idle(0);
        #2;
        chk("l1_occ", bus.occupancy_o, 2);
        chk("l1_first", bus.updatePC_o, 32'h2000);
        idle(0);
        #2;
        chk("l1_second", bus.updatePC_o, 32'h2004);
        chk("l1_second_bhr", bus.updateBhr_o, 8'h22);

        // pause holds two entries for 3 cycles
        step(1, 32'h4000, 1, 8'h33, 1, 32'h4004, 0, 8'h44, 1, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            #2;
            chk("pause_en", bus.updateEn_o, 0);
            chk("pause_occ", bus.occupancy_o, 2);
        end
        idle(0);
        #2;
        chk("resume_pc0", bus.updatePC_o, 32'h4000);
        idle(0);
        #2;
        chk("resume_pc1", bus.updatePC_o, 32'h4004);

        // fill to 7, then simultaneous enqueue/pop; pointers wrap past index 7
        step(1, 32'h5000, 0, 8'h01, 1, 32'h5004, 1, 8'h02, 1, 0);
        step(1, 32'h5008, 0, 8'h03, 1, 32'h500c, 1, 8'h04, 1, 0);
        step(1, 32'h5010, 0, 8'h05, 1, 32'h5014, 1, 8'h06, 1, 0);
        step(1, 32'h5018, 1, 8'h07, 0, 0, 0, 0, 1, 0);
        idle(1);
        #2;
        chk("seven_occ", bus.occupancy_o, 7);
        chk("seven_ready", bus.ready_o, 0);
        idle(0);
        #2;
        chk("seven_pop_pc", bus.updatePC_o, 32'h5000);
        step(1, 32'h501c, 0, 8'h08, 0, 0, 0, 0, 0, 0);
        #2;
        chk("six_occ", bus.occupancy_o, 6);
        chk("six_pc", bus.updatePC_o, 32'h5004);
        exp_pc = '{32'h5008, 32'h500c, 32'h5010, 32'h5014, 32'h5018, 32'h501c};
        for (int i = 0; i < 6; i++) begin
            idle(0);
            #2;
            chk("wrap_order", bus.updatePC_o, exp_pc[i]);
            if (i == 0) chk("six_hold_occ", bus.occupancy_o, 6);
        end
        idle(0);
        #2;
        chk("wrap_empty", bus.occupancy_o, 0);

        // reset with 5 entries queued
        step(1, 32'h6000, 0, 8'h10, 1, 32'h6004, 1, 8'h20, 1, 0);
        step(1, 32'h6008, 0, 8'h30, 1, 32'h600c, 1, 8'h40, 1, 0);
        step(1, 32'h6010, 1, 8'h50, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("rst5_occ_pre", bus.occupancy_o, 5);
        chk("rst5_en", bus.updateEn_o, 0);
        chk("rst5_ready", bus.ready_o, 0);
        idle(0);
        #2;
        chk("rst5_occ", bus.occupancy_o, 0);
        chk("rst5_en_after", bus.updateEn_o, 0);
        chk("rst5_issued", bus.issuedCnt_o, 0);
        chk("rst5_ready_after", bus.ready_o, 1);
        idle(0);
        idle(0);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
